ft245_sync_tx: RTL and testbench
================================

// Module: ft245_sync_tx
// PURPOSE
//  Drains the read port of the 8-bit first-word-fall-through dual-clock FIFO and writes the bytes to the FT2232H
//  synchronous-FIFO (FT245 sync) bus toward the host. Runs entirely in the FT2232H 60 MHz CLKOUT domain.
//  Absorbs TXE# back-pressure with a 2-entry skid buffer and issues a SIWU# send-immediate after an idle timeout.
// PARAMETERS
//  FLUSH_IDLE  16'd255  idle cycles after the last accepted byte before a SIWU# pulse; 0 disables SIWU#.
//  CNT_W       32       width of tx_count_o.
// PORTS
//  clk_i            in   1      FT2232H CLKOUT; single clock; all logic on rising edge.
//  reset_i          in   1      synchronous, active-high reset.
//  fifo_rd_en_o     out  1      pop strobe to the FIFO read port; combinational.
//  fifo_rd_data_i   in   8      FIFO fall-through data; valid in the same cycle as fifo_rd_en_o=1 with empty=0.
//  fifo_rd_empty_i  in   1      FIFO empty flag.
//  ft_txe_n_i       in   1      FT2232H TXE#; low = chip can accept data.
//  ft_wr_n_o        out  1      FT2232H WR#; registered.
//  ft_data_o        out  8      FT2232H D[7:0]; registered.
//  ft_oe_n_o        out  1      FT2232H OE#; constant 1 (transmit-only block).
//  ft_siwu_n_o      out  1      FT2232H SIWU#; registered, active-low 1-cycle pulse.
//  tx_count_o       out  CNT_W  bytes accepted by the FT2232H since reset; wraps at 2^CNT_W.
//  busy_o           out  1      1 when skid buffer is non-empty or the FSM is not IDLE.
// BEHAVIOUR
//  Reset (sync, reset_i=1 at edge): ft_wr_n_o=1, ft_siwu_n_o=1, ft_data_o=8'h00, tx_count_o=0, busy_o=0,
//   buffer count=0, idle counter=0, flush_pending=0, state=IDLE. fifo_rd_en_o=0 while reset_i=1.
//   Reset mid-transfer discards buffered bytes; bytes already popped from the FIFO are lost.
//  Accept: a byte is transferred at an edge where ft_wr_n_o=0 and ft_txe_n_i=0 (pop = ~ft_wr_n_o & ~ft_txe_n_i).
//   A byte presented with WR#=0 while TXE#=1 is NOT transferred; it is held and ft_data_o stays stable.
//  Skid buffer: 2 entries, count 0..2. space = (count<2) | pop.
//   fifo_rd_en_o = ~reset_i & ~fifo_rd_empty_i & space & (state!=SIWU); push = fifo_rd_en_o, data captured same edge.
//   Simultaneous push+pop at count=2 is legal (count stays 2). Head advances only on pop. ft_data_o = head entry.
//  WR# next = ~(count_next>0 & ~ft_txe_n_i & state_next==SEND). TXE# rising -> WR# high one cycle later;
//   latency: FIFO non-empty -> first WR# low = 1 cycle (pop cycle, then WR# registered).
//  FSM (state enum in package):
//   IDLE  : count==0. Leaves to SEND when count_next>0. If flush_pending, idle counter increments;
//           at idle==FLUSH_IDLE-1 -> SIWU. Counter clears on any push.
//   SEND  : WR# driven per rule above. On every pop: tx_count_o+=1, flush_pending=1. -> IDLE when count_next==0.
//   SIWU  : exactly 1 cycle: ft_siwu_n_o=0, ft_wr_n_o=1, no FIFO pop; clears flush_pending and idle counter -> IDLE.
//  FLUSH_IDLE=0: SIWU never entered, ft_siwu_n_o constant 1.
//  tx_count_o wraps from all-ones to 0 without flag. busy_o registered from state_next/count_next.
// STRUCTURE
//  Package ft_tx_pkg: typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_SIWU} ft_tx_state_t; localparam FT_DATA_W=8.
//  Sub-module ft_tx_skid: 2-entry byte skid buffer (push, pop, data_in, head, count); FSM, counters, pins in top.
// TESTING
//  1 FIFO holds 8'h01..8'h10, TXE# low -> 16 consecutive WR# low cycles, D=01..10 in order, tx_count_o=16.
//  2 TXE# high for 3 cycles mid-burst at byte 8'h05 -> 8'h05 held on D, not counted, resumes with no loss/dup.
//  3 FIFO empty toggling every cycle (1 byte/2 cycles) -> WR# pulses, each byte written once, count correct.
//  4 FLUSH_IDLE=4: write 3 bytes then empty -> ft_siwu_n_o low exactly 1 cycle, 4 cycles after last accept;
//    no second pulse without new data.
//  5 reset_i asserted while count=2 and WR# low -> next cycle WR#=1, D=00, tx_count_o=0, busy_o=0, no pop.
//  6 tx_count_o preset near wrap (CNT_W=4): 17 bytes -> value 1, no stall.

Source files
------------

// File: rtl/ft_tx_pkg.sv
// Shared types for the FT245 synchronous-FIFO transmit path.
package ft_tx_pkg;

    localparam int FT_DATA_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_SIWU
    } ft_tx_state_t;

endpackage

// File: rtl/ft_tx_skid.sv
// Two-entry byte skid buffer; head is a flop so the bus data stays glitch-free.
module ft_tx_skid
    import ft_tx_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 push,
    input  logic                 pop,
    input  logic [FT_DATA_W-1:0] data_in,
    output logic [FT_DATA_W-1:0] head,
    output logic [1:0]           count
);

    logic [FT_DATA_W-1:0] tail;

    // Head only moves forward on pop, except when a byte lands in an empty buffer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= data_in;
                    end else begin
                        head <= data_in;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head <= tail;
                    end
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= data_in;
                    end else begin
                        tail <= data_in;
                    end
                    count <= count + 2'd1;
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule

// File: rtl/ft245_sync_tx.sv
// Drains a FWFT FIFO onto the FT2232H FT245-sync bus, absorbing TXE# back-pressure
// and issuing a SIWU# send-immediate once the link has been idle long enough.
module ft245_sync_tx
    import ft_tx_pkg::*;
#(
    parameter logic [15:0] FLUSH_IDLE = 16'd255,
    parameter int          CNT_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output logic                 fifo_rd_en_o,
    input  logic [FT_DATA_W-1:0] fifo_rd_data_i,
    input  logic                 fifo_rd_empty_i,
    input  logic                 ft_txe_n_i,
    output logic                 ft_wr_n_o,
    output logic [FT_DATA_W-1:0] ft_data_o,
    output logic                 ft_oe_n_o,
    output logic                 ft_siwu_n_o,
    output logic [CNT_W-1:0]     tx_count_o,
    output logic                 busy_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ft_tx_state_t state, state_next;
    logic [1:0]   count, count_next;
    logic [15:0]  idle_cnt, idle_next;
    logic         flush_pending, flush_next;
    logic         pop, push, space;

    assign pop          = ~ft_wr_n_o & ~ft_txe_n_i;
    assign space        = (count < 2'd2) | pop;
    assign fifo_rd_en_o = ~reset_i & ~fifo_rd_empty_i & space & (state != TX_SIWU);
    assign push         = fifo_rd_en_o;
    assign count_next   = count + {1'b0, push} - {1'b0, pop};
    assign ft_oe_n_o    = 1'b1;

    ft_tx_skid u_skid (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (push),
        .pop     (pop),
        .data_in (fifo_rd_data_i),
        .head    (ft_data_o),
        .count   (count)
    );

    // The idle timer only runs after at least one byte has gone out since the last flush.
    always_comb begin
        state_next = state;
        idle_next  = idle_cnt;
        flush_next = flush_pending;
        unique case (state)
            TX_IDLE: begin
                if (count_next != 2'd0) begin
                    state_next = TX_SEND;
                    idle_next  = '0;
                end else if (flush_pending && (FLUSH_IDLE != 16'd0)) begin
                    if (idle_cnt == FLUSH_IDLE - 16'd1) begin
                        state_next = TX_SIWU;
                    end else begin
                        idle_next = idle_cnt + 16'd1;
                    end
                end
            end
            TX_SEND: begin
                idle_next = '0;
                if (pop) begin
                    flush_next = 1'b1;
                end
                if (count_next == 2'd0) begin
                    state_next = TX_IDLE;
                end
            end
            TX_SIWU: begin
                flush_next = 1'b0;
                idle_next  = '0;
                state_next = TX_IDLE;
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= TX_IDLE;
            idle_cnt      <= '0;
            flush_pending <= 1'b0;
            ft_wr_n_o     <= 1'b1;
            ft_siwu_n_o   <= 1'b1;
            tx_count_o    <= '0;
            busy_o        <= 1'b0;
        end else begin
            state         <= state_next;
            idle_cnt      <= idle_next;
            flush_pending <= flush_next;
            ft_wr_n_o     <= ~((count_next != 2'd0) & ~ft_txe_n_i & (state_next == TX_SEND));
            ft_siwu_n_o   <= (state_next != TX_SIWU);
            busy_o        <= (count_next != 2'd0) | (state_next != TX_IDLE);
            if (pop) begin
                tx_count_o <= tx_count_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ft245_sync_tx.sv
// Directed bench for ft245_sync_tx with a queue-based model of the byte stream and flush timer.
module tb_ft245_sync_tx;

    localparam logic [15:0] TB_FLUSH = 16'd4;
    localparam int          TB_CNT_W = 4;

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b1;
    logic                fifo_rd_en_o;
    logic [7:0]          fifo_rd_data_i = 8'h00;
    logic                fifo_rd_empty_i = 1'b1;
    logic                ft_txe_n_i = 1'b1;
    logic                ft_wr_n_o;
    logic [7:0]          ft_data_o;
    logic                ft_oe_n_o;
    logic                ft_siwu_n_o;
    logic [TB_CNT_W-1:0] tx_count_o;
    logic                busy_o;

    ft245_sync_tx #(.FLUSH_IDLE(TB_FLUSH), .CNT_W(TB_CNT_W)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .fifo_rd_en_o    (fifo_rd_en_o),
        .fifo_rd_data_i  (fifo_rd_data_i),
        .fifo_rd_empty_i (fifo_rd_empty_i),
        .ft_txe_n_i      (ft_txe_n_i),
        .ft_wr_n_o       (ft_wr_n_o),
        .ft_data_o       (ft_data_o),
        .ft_oe_n_o       (ft_oe_n_o),
        .ft_siwu_n_o     (ft_siwu_n_o),
        .tx_count_o      (tx_count_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Environment FIFO and the model of what the block is holding / has delivered.
    logic [7:0] fifo_q[$];
    logic [7:0] m_q[$];
    logic [7:0] delivered[$];
    logic       m_wr_low = 1'b0;
    logic       m_siwu = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_flush = 1'b0;
    int         m_idle = 0;
    int         m_cnt = 0;
    int         edge_no = 0;
    int         last_acc_edge = -1;
    int         siwu_edge = -1;
    int         siwu_low_cnt = 0;
    int         wr_run = 0;
    int         wr_max_run = 0;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic checkOutput();
        compare("wr_n", {31'd0, ft_wr_n_o}, {31'd0, ~m_wr_low});
        compare("siwu_n", {31'd0, ft_siwu_n_o}, {31'd0, ~m_siwu});
        compare("busy", {31'd0, busy_o}, {31'd0, m_busy});
        compare("oe_n", {31'd0, ft_oe_n_o}, 32'd1);
        compare("tx_count", {28'd0, tx_count_o}, m_cnt % 16);
        if (m_wr_low && m_q.size() != 0) begin
            compare("data", {24'd0, ft_data_o}, {24'd0, m_q[0]});
        end
        if (ft_wr_n_o == 1'b0) begin
            wr_run++;
            if (wr_run > wr_max_run) wr_max_run = wr_run;
        end else begin
            wr_run = 0;
        end
        if (ft_siwu_n_o == 1'b0) begin
            siwu_low_cnt++;
            siwu_edge = edge_no;
        end
    endtask

    // One clock: drive at negedge, predict the edge from the queue model, check #1 after posedge.
    task automatic applyStimulus(input logic rst, input logic txe_n, input logic hide);
        logic       acc, exp_rd, was_empty, pulse, dut_pop;
        logic [7:0] in_byte;
        @(negedge clk_i);
        reset_i         = rst;
        ft_txe_n_i      = txe_n;
        fifo_rd_empty_i = hide || (fifo_q.size() == 0);
        fifo_rd_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        in_byte         = fifo_rd_data_i;
        #1;
        acc    = m_wr_low && !txe_n;
        exp_rd = !rst && !fifo_rd_empty_i && ((m_q.size() < 2) || acc) && !m_siwu;
        compare("rd_en", {31'd0, fifo_rd_en_o}, {31'd0, exp_rd});
        dut_pop = fifo_rd_en_o;
        @(posedge clk_i);
        edge_no++;
        if (dut_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (rst) begin
            m_q.delete();
            m_wr_low = 1'b0;
            m_siwu   = 1'b0;
            m_busy   = 1'b0;
            m_flush  = 1'b0;
            m_idle   = 0;
            m_cnt    = 0;
        end else begin
            was_empty = (m_q.size() == 0);
            pulse     = 1'b0;
            if (acc && m_q.size() != 0) begin
                delivered.push_back(m_q.pop_front());
                m_cnt++;
                last_acc_edge = edge_no;
            end
            if (exp_rd) m_q.push_back(in_byte);
            if (m_siwu) begin
                m_flush = 1'b0;
                m_idle  = 0;
            end else if (!was_empty) begin
                if (acc) m_flush = 1'b1;
                m_idle = 0;
            end else if (exp_rd) begin
                m_idle = 0;
            end else if (m_flush && TB_FLUSH != 16'd0) begin
                if (m_idle == int'(TB_FLUSH) - 1) pulse = 1'b1;
                else m_idle++;
            end
            m_siwu   = pulse;
            m_wr_low = (m_q.size() != 0) && !txe_n;
            m_busy   = (m_q.size() != 0) || pulse;
        end
        #1;
        checkOutput();
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        fifo_q.delete();
        delivered.delete();
        wr_run        = 0;
        wr_max_run    = 0;
        siwu_low_cnt  = 0;
        siwu_edge     = -1;
        last_acc_edge = -1;
    endtask

    task automatic loadFifo(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
    endtask

    task automatic checkSeq(input string name, input logic [7:0] base, input int n);
        compare({name, "_len"}, delivered.size(), n);
        for (int i = 0; i < n && i < delivered.size(); i++) begin
            compare({name, "_byte"}, {24'd0, delivered[i]}, {24'd0, base + 8'(i)});
        end
    endtask

    initial begin
        // Reset state
        resetDut();
        compare("rst_wr_n", {31'd0, ft_wr_n_o}, 32'd1);
        compare("rst_siwu_n", {31'd0, ft_siwu_n_o}, 32'd1);
        compare("rst_data", {24'd0, ft_data_o}, 32'h00);
        compare("rst_count", {28'd0, tx_count_o}, 32'd0);
        compare("rst_busy", {31'd0, busy_o}, 32'd0);

        // 1: sixteen bytes back to back; first WR# low one edge after FIFO non-empty
        loadFifo(8'h01, 16);
        applyStimulus(1'b0, 1'b0, 1'b0);
        compare("t1_first_wr_n", {31'd0, ft_wr_n_o}, 32'd0);
        compare("t1_first_data", {24'd0, ft_data_o}, 32'h01);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkSeq("t1", 8'h01, 16);
        compare("t1_wr_run", wr_max_run, 16);
        compare("t1_count_wrapped", {28'd0, tx_count_o}, 32'd0);

        // 2: TXE# high for three edges while 8'h05 is on the bus
        resetDut();
        loadFifo(8'h01, 10);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        compare("t2_data_05", {24'd0, ft_data_o}, 32'h05);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        compare("t2_held_data", {24'd0, ft_data_o}, 32'h05);
        compare("t2_held_count", {28'd0, tx_count_o}, 32'd4);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkSeq("t2", 8'h01, 10);

        // 3: FIFO empty flag toggling every cycle
        resetDut();
        loadFifo(8'hA0, 6);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'(i % 2));
        checkSeq("t3", 8'hA0, 6);
        compare("t3_count", {28'd0, tx_count_o}, 32'd6);

        // 4: SIWU# pulse four edges after the last accept, and only once
        resetDut();
        loadFifo(8'h31, 3);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkSeq("t4", 8'h31, 3);
        compare("t4_siwu_pulses", siwu_low_cnt, 1);
        compare("t4_siwu_delay", siwu_edge - last_acc_edge, 4);

        // 5: reset with two bytes buffered and WR# low
        resetDut();
        loadFifo(8'h01, 6);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        compare("t5_pre_wr_n", {31'd0, ft_wr_n_o}, 32'd0);
        compare("t5_pre_busy", {31'd0, busy_o}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        compare("t5_wr_n", {31'd0, ft_wr_n_o}, 32'd1);
        compare("t5_data", {24'd0, ft_data_o}, 32'h00);
        compare("t5_count", {28'd0, tx_count_o}, 32'd0);
        compare("t5_busy", {31'd0, busy_o}, 32'd0);
        compare("t5_fifo_left", fifo_q.size(), 3);
        fifo_q.delete();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // 6: 17 bytes through a 4-bit counter
        resetDut();
        loadFifo(8'h01, 17);
        for (int i = 0; i < 22; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkSeq("t6", 8'h01, 17);
        compare("t6_count", {28'd0, tx_count_o}, 32'd1);
        compare("t6_wr_run", wr_max_run, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
